alu_arbiter: RTL
================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit ALU. It accepts operation requests (SrcA, SrcB, 3-bit ALUControl) from two independent requesters, such as the main datapath and the branch/address unit. It drives the single ALU instance through registered operand ports and returns the captured result and Zero flag to the winning requester over a valid/ready handshake. The ALU stays external and purely combinational; this block owns all sequencing state.

## Interface
- No parameters. Requester count is fixed at 2 and data width at 32.
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- ReqValid  input  2  per-requester request valid; bit i = requester i
- ReqReady  output  2  per-requester accept; at most one bit high
- Req0SrcA, Req0SrcB  input  32 each  requester 0 operands
- Req0Ctrl  input  3  requester 0 ALU operation code
- Req1SrcA, Req1SrcB  input  32 each  requester 1 operands
- Req1Ctrl  input  3  requester 1 ALU operation code
- ALUSrcA, ALUSrcB  output  32 each  registered operands to the ALU
- ALUControl  output  3  registered operation code to the ALU
- ALUResult  input  32  ALU combinational result
- ALUZero  input  1  ALU Zero flag
- RspValid  output  2  one-hot response valid to the owning requester
- RspReady  input  2  per-requester response accept
- RspResult  output  32  captured result, shared by both requesters
- RspZero  output  1  captured Zero flag, shared by both requesters
- Busy  output  1  high whenever the state is not IDLE
- Owner  output  1  index of the requester currently owning the ALU

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE**
  - Arbitrate among the asserted ReqValid bits.
  - If only one bit is set, grant it.
  - If both are set, grant the requester that is not LastGrant.
  - ReqReady[g] = 1 combinationally for the granted g only. Ready may depend on valid.
  - On the handshake edge: latch Req{g}SrcA/SrcB/Ctrl into ALUSrcA/ALUSrcB/ALUControl, set Owner = g, set LastGrant = g, then go to EXEC.
- **EXEC** (exactly 1 cycle)
  - The ALU evaluates the registered operands.
  - At the end of the cycle, capture ALUResult into RspResult and ALUZero into RspZero, then go to DONE.
- **DONE**
  - RspValid[Owner] = 1 and the other bit = 0. RspResult and RspZero are held stable.
  - On RspReady[Owner] = 1, go to IDLE. RspReady of the non-owner is ignored.
- ReqReady = 0 in EXEC and DONE. Requests pending then are held by the requester; nothing is queued.
- After returning to IDLE, ALUSrcA/ALUSrcB/ALUControl keep their last values. They only change on a handshake.
- ALUControl is passed through unchecked. For undefined codes (011, 101) the ALU result is 0, so RspResult = 0 and RspZero = 1.
- No arithmetic is performed here. Widths pass through unmodified.

## Timing
- Reset values (asynchronous, immediate on reset_n = 0):
  - State = IDLE, LastGrant = 1 (so requester 0 wins the first contention), Owner = 0.
  - ALUSrcA = ALUSrcB = 0, ALUControl = 000, RspResult = 0, RspZero = 0.
  - RspValid = 00, Busy = 0.
  - ReqReady follows arbitration of ReqValid once reset_n = 1. It is 00 while reset_n = 0.
- Latency: handshake at edge k, EXEC during cycle k..k+1, RspValid high from edge k+1 (the cycle after EXEC).
  - Request-accept to response-valid is 2 edges.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, DONE with immediate RspReady).
- A response held indefinitely by RspReady = 0 blocks both requesters. This is intentional.
- Simultaneous events:
  - Both requesters valid in IDLE: round-robin as above.
  - The loser's ReqValid stays high. It wins the next IDLE cycle even if the other requester re-requests.
- Reset mid-operation (in EXEC or DONE): the operation is discarded, no response is issued, and LastGrant returns to 1.
- Busy = (state != IDLE), registered.

## Test plan
- **Single request:** after reset, requester 0 sends SrcA = 0x0000F0F0, SrcB = 0x00000FF0, Ctrl = 000. Required: ReqReady = 01 in the same cycle, RspValid = 01 two edges later, RspResult = 0x000000F0, RspZero = 0.
- **Contention and round-robin:** both ReqValid held high continuously, requester 0 sends Ctrl = 010 (3 + 4), requester 1 sends Ctrl = 110 (5 − 5), RspReady always 11. Required grants alternate 0, 1, 0, 1. Responses are 7 with Zero = 0, then 0 with Zero = 1.
- **Response backpressure:** requester 1 sends SLT with 2 < 9 and holds RspReady[1] = 0 for 5 cycles. Required: RspValid = 10 and RspResult = 1 stable throughout, ReqReady = 00 while requester 0 is valid, and requester 0 is granted in the first IDLE cycle after RspReady[1] rises.
- **Non-owner ready ignored:** requester 0 owns DONE and RspReady = 10 is applied. Required: the block stays in DONE and RspValid stays 01.
- **Reset mid-operation:** reset_n is pulsed low during EXEC. Required: all outputs return to their reset values immediately, no RspValid pulse occurs, and the next contention grants requester 0.
- **Undefined opcode:** Ctrl = 011 with any operands. Required: RspResult = 0 and RspZero = 1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one external combinational ALU
// between two requesters over valid/ready request and response handshakes.
module alu_arbiter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  ReqValid_i,
    output logic [1:0]  ReqReady_o,
    input  logic [31:0] Req0SrcA_i,
    input  logic [31:0] Req0SrcB_i,
    input  logic [2:0]  Req0Ctrl_i,
    input  logic [31:0] Req1SrcA_i,
    input  logic [31:0] Req1SrcB_i,
    input  logic [2:0]  Req1Ctrl_i,
    output logic [31:0] ALUSrcA_o,
    output logic [31:0] ALUSrcB_o,
    output logic [2:0]  ALUControl_o,
    input  logic [31:0] ALUResult_i,
    input  logic        ALUZero_i,
    output logic [1:0]  RspValid_o,
    input  logic [1:0]  RspReady_i,
    output logic [31:0] RspResult_o,
    output logic        RspZero_o,
    output logic        Busy_o,
    output logic        Owner_o
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        busy_q, busy_d;
    logic        grant;
    logic        handshake;

    // With both requesters valid the one not served last wins; otherwise the lone requester.
    assign grant = (ReqValid_i == 2'b11) ? ~last_grant_q : ReqValid_i[1];

    always_comb begin
        ReqReady_o = 2'b00;
        if (rst_ni && (state_q == IDLE) && (ReqValid_i != 2'b00)) begin
            ReqReady_o[grant] = 1'b1;
        end
    end

    assign handshake = |ReqReady_o;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    alu_a_d      = grant ? Req1SrcA_i : Req0SrcA_i;
                    alu_b_d      = grant ? Req1SrcB_i : Req0SrcB_i;
                    alu_ctrl_d   = grant ? Req1Ctrl_i : Req0Ctrl_i;
                    owner_d      = grant;
                    last_grant_d = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = ALUResult_i;
                rsp_zero_d   = ALUZero_i;
                state_d      = DONE;
            end
            DONE: begin
                // Only the owner's ready releases the ALU.
                if (RspReady_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_ctrl_q   <= 3'd0;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        RspValid_o = 2'b00;
        if (state_q == DONE) begin
            RspValid_o[owner_q] = 1'b1;
        end
    end

    assign ALUSrcA_o    = alu_a_q;
    assign ALUSrcB_o    = alu_b_q;
    assign ALUControl_o = alu_ctrl_q;
    assign RspResult_o  = rsp_result_q;
    assign RspZero_o    = rsp_zero_q;
    assign Busy_o       = busy_q;
    assign Owner_o      = owner_q;

endmodule
